serve_controller: RTL and testbench
===================================

SERVE_CONTROLLER -- requirements
Module: serve_controller

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win a game; legal range 1..15.
REQ-002 Parameter FRAMES_PER_SEC, default 60: frame_tick pulses per second; legal range 2..63.
REQ-003 Parameter COUNT_SEC, default 3: serve countdown length in seconds; legal range 1..3.
REQ-004 Parameter OVER_SEC, default 5: seconds spent in OVER; legal range 1..7.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 miss_left  in  1  one-cycle pulse; ball passed the left paddle, so right player scores.
REQ-009 miss_right  in  1  one-cycle pulse; ball passed the right paddle, so left player scores.
REQ-010 key_left  in  2  left player up/down keys, level.
REQ-011 key_right  in  2  right player up/down keys, level.
REQ-012 pause_key  in  1  pause key, level.
REQ-013 launch  out  1  one-cycle pulse that releases the ball.
REQ-014 launch_dir  out  1  ball direction, valid with launch: 1 = toward right, 0 = toward left.
REQ-015 serve_side  out  1  current server: 0 = left, 1 = right.
REQ-016 gra_still  out  1  freezes ball and paddle animation when 1.
REQ-017 countdown  out  2  seconds remaining, for the text overlay.
REQ-018 score_left, score_right  out  4 each  binary scores.
REQ-019 game_over  out  1  high while in OVER.
REQ-020 winner  out  1  0 = left won, 1 = right won; valid while game_over is high.
REQ-021 state  out  3  encoding: IDLE=0, COUNTDOWN=1, WAIT_KEY=2, PLAY=3, PAUSE=4, OVER=5.

Function
REQ-022 Key activity: left_act = |key_left; right_act = |key_right.
REQ-023 Pause edge: pause_key is registered; pause_edge = pause_key & ~pause_q.
REQ-024 Frame counter: 6 bits; counts frame_tick; cleared on every entry to COUNTDOWN and to OVER.
REQ-025 Seconds step: when frame_tick arrives with the frame counter at FRAMES_PER_SEC-1, the counter wraps to 0 and a one-second step occurs.
REQ-026 gra_still: 0 only in PLAY; 1 in every other state.
REQ-027 IDLE -> COUNTDOWN on left_act | right_act, with these actions in the same cycle:
- clear both scores;
- set serve_side = 0;
- load countdown = COUNT_SEC.
REQ-028 COUNTDOWN: each second step decrements countdown.
- A step taking countdown from 1 to 0 moves to WAIT_KEY.
REQ-029 WAIT_KEY: countdown = 0.
- Server's key active (left_act if serve_side=0, right_act if serve_side=1) -> assert launch for exactly one cycle, go to PLAY.
- launch_dir = ~serve_side.
- The non-server's keys are ignored.
REQ-030 PLAY, miss_left: score_right increments and serve_side becomes 0 (the conceding player serves).
REQ-031 PLAY, miss_right: score_left increments and serve_side becomes 1.
REQ-032 PLAY, miss_left and miss_right in the same cycle: miss_left wins; miss_right is dropped.
REQ-033 After a scored point:
- new score equal to WIN_SCORE -> OVER, winner = scoring side;
- otherwise -> COUNTDOWN with countdown = COUNT_SEC.
REQ-034 Score width: scores never exceed WIN_SCORE; no 4-bit wrap is possible.
REQ-035 PLAY, pause_edge with no miss: go to PAUSE. A miss takes priority over pause_edge in the same cycle.
REQ-036 PAUSE: pause_edge returns to PLAY. Misses are ignored in PAUSE.
REQ-037 pause_edge is ignored in every state other than PLAY and PAUSE.
REQ-038 OVER: exit to IDLE after OVER_SEC second steps (3-bit second counter).
- Scores and winner hold their values until the next IDLE -> COUNTDOWN transition.
REQ-039 launch is asserted only on the WAIT_KEY -> PLAY transition; never twice for one serve.

Reset
REQ-040 While reset is high, all outputs and registers take these values:
- state = IDLE;
- scores = 0, countdown = 0, serve_side = 0, winner = 0;
- launch = 0, game_over = 0, gra_still = 1;
- frame counter, second counter and pause_q = 0.
REQ-041 Reset asserted mid-countdown, mid-play or in PAUSE aborts immediately to the REQ-040 values with no launch pulse.
REQ-042 After reset deasserts, the first transition requires a fresh key press in IDLE.

Verification (bench runs with FRAMES_PER_SEC=2, COUNT_SEC=3, OVER_SEC=2, WIN_SCORE=2)
REQ-043 Start:
- Stimulus: key_left=01 pulse in IDLE.
- Required: state=COUNTDOWN and countdown=3; after 6 frame_ticks countdown=0 and state=WAIT_KEY.
REQ-044 Serve gating:
- Stimulus: in WAIT_KEY with serve_side=0, press key_right=10, then key_left=10.
- Required: no launch on the right press; one launch pulse with launch_dir=1 on the left press; state=PLAY; gra_still=0.
REQ-045 Simultaneous miss:
- Stimulus: in PLAY, miss_left and miss_right together.
- Required: score_right=1, score_left=0, serve_side=0, state=COUNTDOWN, countdown=3.
REQ-046 Game end:
- Stimulus: a second miss_left.
- Required: score_right=2, state=OVER, game_over=1, winner=1; after 4 frame_ticks state=IDLE with scores still 0/2; the next key press clears both scores.
REQ-047 Pause:
- Stimulus: in PLAY, pause_key held high for 10 cycles, then a miss_right pulse, then release and press pause_key again.
- Required: PAUSE on the first edge; miss ignored (score_left unchanged); gra_still=1; PLAY on the second edge.
REQ-048 Reset mid-countdown:
- Stimulus: assert reset with countdown=2 and score_left=1.
- Required: all REQ-040 values and no launch pulse.

Source files
------------

// File: rtl/serve_controller.sv
// serve_controller
//   Game-flow controller for a two-player paddle game. Waits for any key in
//   IDLE, runs a serve countdown, releases the ball when the server presses a
//   key, tracks the score, handles pause, and shows the game-over screen for a
//   fixed time before returning to IDLE.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   frame_tick   one pulse per video frame (time base for countdowns)
//   miss_left    ball passed left paddle -> right player scores
//   miss_right   ball passed right paddle -> left player scores
//   key_left     left player up/down keys (level)
//   key_right    right player up/down keys (level)
//   pause_key    pause key (level, rising edge toggles pause)
//   launch       one-cycle ball release pulse
//   launch_dir   direction qualified by launch: 1 = toward right
//   serve_side   current server: 0 = left, 1 = right
//   gra_still    freeze animation; low only while playing
//   countdown    seconds left in the serve countdown
//   score_left   left player score
//   score_right  right player score
//   game_over    high while the game-over screen is shown
//   winner       0 = left won, 1 = right won (qualified by game_over)
//   state        debug view of the FSM: IDLE=0 COUNTDOWN=1 WAIT_KEY=2
//                PLAY=3 PAUSE=4 OVER=5
//
// Handshake: there are no valid/ready pairs here; launch is a single-cycle
// strobe and launch_dir is only meaningful in the cycle launch is high.
module serve_controller #(
  parameter int WIN_SCORE      = 7,
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNT_SEC      = 3,
  parameter int OVER_SEC       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic [1:0] key_left,
  input  logic [1:0] key_right,
  input  logic       pause_key,
  output logic       launch,
  output logic       launch_dir,
  output logic       serve_side,
  output logic       gra_still,
  output logic [1:0] countdown,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    WAIT_KEY  = 3'd2,
    PLAY      = 3'd3,
    PAUSE     = 3'd4,
    OVER      = 3'd5
  } state_t;

  localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [1:0] COUNT_LOAD = 2'(COUNT_SEC);
  localparam logic [2:0] OVER_LAST  = 3'(OVER_SEC - 1);

  state_t     st;
  logic [5:0] frame_cnt;
  logic [2:0] sec_cnt;
  logic       pause_q;

  logic       left_act;
  logic       right_act;
  logic       server_act;
  logic       pause_edge;
  logic       sec_step;
  logic [3:0] score_left_inc;
  logic [3:0] score_right_inc;

  assign left_act        = |key_left;
  assign right_act       = |key_right;
  // Only the serving player's keys can release the ball.
  assign server_act      = serve_side ? right_act : left_act;
  assign pause_edge      = pause_key & ~pause_q;
  assign sec_step        = frame_tick && (frame_cnt == FRAME_LAST);
  assign score_left_inc  = score_left + 4'd1;
  assign score_right_inc = score_right + 4'd1;
  assign state           = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      countdown   <= 2'd0;
      serve_side  <= 1'b0;
      winner      <= 1'b0;
      launch      <= 1'b0;
      launch_dir  <= 1'b0;
      game_over   <= 1'b0;
      gra_still   <= 1'b1;
      frame_cnt   <= 6'd0;
      sec_cnt     <= 3'd0;
      pause_q     <= 1'b0;
    end else begin
      pause_q <= pause_key;
      launch  <= 1'b0;
      // Free-running frame counter; state entries below override it to 0 so
      // every countdown and game-over period starts on a whole second.
      if (frame_tick) frame_cnt <= sec_step ? 6'd0 : frame_cnt + 6'd1;

      case (st)
        IDLE: begin
          if (left_act || right_act) begin
            score_left  <= 4'd0;
            score_right <= 4'd0;
            winner      <= 1'b0;
            serve_side  <= 1'b0;
            countdown   <= COUNT_LOAD;
            frame_cnt   <= 6'd0;
            st          <= COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (sec_step) begin
            countdown <= countdown - 2'd1;
            if (countdown == 2'd1) st <= WAIT_KEY;
          end
        end
        WAIT_KEY: begin
          if (server_act) begin
            launch     <= 1'b1;
            launch_dir <= ~serve_side;
            gra_still  <= 1'b0;
            st         <= PLAY;
          end
        end
        PLAY: begin
          // miss_left outranks miss_right, and any miss outranks pause.
          if (miss_left) begin
            score_right <= score_right_inc;
            serve_side  <= 1'b0;
            gra_still   <= 1'b1;
            frame_cnt   <= 6'd0;
            if (score_right_inc == WIN) begin
              winner    <= 1'b1;
              game_over <= 1'b1;
              sec_cnt   <= 3'd0;
              st        <= OVER;
            end else begin
              countdown <= COUNT_LOAD;
              st        <= COUNTDOWN;
            end
          end else if (miss_right) begin
            score_left <= score_left_inc;
            serve_side <= 1'b1;
            gra_still  <= 1'b1;
            frame_cnt  <= 6'd0;
            if (score_left_inc == WIN) begin
              winner    <= 1'b0;
              game_over <= 1'b1;
              sec_cnt   <= 3'd0;
              st        <= OVER;
            end else begin
              countdown <= COUNT_LOAD;
              st        <= COUNTDOWN;
            end
          end else if (pause_edge) begin
            gra_still <= 1'b1;
            st        <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_edge) begin
            gra_still <= 1'b0;
            st        <= PLAY;
          end
        end
        OVER: begin
          if (sec_step) begin
            if (sec_cnt == OVER_LAST) begin
              game_over <= 1'b0;
              st        <= IDLE;
            end else begin
              sec_cnt <= sec_cnt + 3'd1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serve_controller.sv
module tb_serve_controller;

  localparam int FPS = 2;
  localparam int CS  = 3;
  localparam int OS  = 2;
  localparam int WS  = 2;

  localparam int S_IDLE = 0, S_CD = 1, S_WAIT = 2, S_PLAY = 3, S_PAUSE = 4, S_OVER = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [1:0] key_left = 2'b00;
  logic [1:0] key_right = 2'b00;
  logic       pause_key = 1'b0;

  logic       launch, launch_dir, serve_side, gra_still, game_over, winner;
  logic [1:0] countdown;
  logic [3:0] score_left, score_right;
  logic [2:0] state;

  always #5 clk = ~clk;

  serve_controller #(
    .WIN_SCORE(WS), .FRAMES_PER_SEC(FPS), .COUNT_SEC(CS), .OVER_SEC(OS)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right),
    .key_left(key_left), .key_right(key_right), .pause_key(pause_key),
    .launch(launch), .launch_dir(launch_dir), .serve_side(serve_side),
    .gra_still(gra_still), .countdown(countdown),
    .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner), .state(state)
  );

  int n_pass   = 0;
  int n_total  = 0;
  int n_launch = 0;
  int launch_snap;
  bit started  = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks game state at the level of rules: frames elapsed since the start
  // of a timed phase, and derives the displayed countdown from that.
  int m_state = S_IDLE, m_sl = 0, m_sr = 0, m_serve = 0, m_winner = 0, m_ticks = 0;
  bit m_launch = 1'b0, m_dir = 1'b0, m_pq = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int st, sl, sr, sv, wn, tk;
    bit ln, dr, pe;
    if (reset) begin
      m_state <= S_IDLE; m_sl <= 0; m_sr <= 0; m_serve <= 0; m_winner <= 0;
      m_ticks <= 0; m_launch <= 1'b0; m_dir <= 1'b0; m_pq <= 1'b0;
    end else begin
      st = m_state; sl = m_sl; sr = m_sr; sv = m_serve; wn = m_winner;
      tk = m_ticks; ln = 1'b0; dr = m_dir;
      pe = pause_key && !m_pq;
      case (st)
        S_IDLE:
          if (key_left != 0 || key_right != 0) begin
            sl = 0; sr = 0; sv = 0; wn = 0; tk = 0; st = S_CD;
          end
        S_CD:
          if (frame_tick) begin
            tk++;
            if (tk == CS * FPS) st = S_WAIT;
          end
        S_WAIT:
          if ((sv == 0 && key_left != 0) || (sv == 1 && key_right != 0)) begin
            ln = 1'b1; dr = (sv == 0); st = S_PLAY;
          end
        S_PLAY:
          if (miss_left) begin
            sr++; sv = 0; tk = 0;
            if (sr == WS) begin st = S_OVER; wn = 1; end else st = S_CD;
          end else if (miss_right) begin
            sl++; sv = 1; tk = 0;
            if (sl == WS) begin st = S_OVER; wn = 0; end else st = S_CD;
          end else if (pe) st = S_PAUSE;
        S_PAUSE:
          if (pe) st = S_PLAY;
        S_OVER:
          if (frame_tick) begin
            tk++;
            if (tk == OS * FPS) st = S_IDLE;
          end
        default: st = S_IDLE;
      endcase
      m_state <= st; m_sl <= sl; m_sr <= sr; m_serve <= sv; m_winner <= wn;
      m_ticks <= tk; m_launch <= ln; m_dir <= dr; m_pq <= pause_key;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("state", int'(state), m_state);
      check("countdown", int'(countdown), (m_state == S_CD) ? CS - m_ticks / FPS : 0);
      check("score_left", int'(score_left), m_sl);
      check("score_right", int'(score_right), m_sr);
      check("serve_side", int'(serve_side), m_serve);
      check("gra_still", int'(gra_still), (m_state != S_PLAY) ? 1 : 0);
      check("game_over", int'(game_over), (m_state == S_OVER) ? 1 : 0);
      check("winner", int'(winner), m_winner);
      check("launch", int'(launch), int'(m_launch));
      if (m_launch) check("launch_dir", int'(launch_dir), int'(m_dir));
      if (launch) n_launch++;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 3 time units after a rising edge and are sampled by the
  // next one; the task returns 3 units after that edge.
  task automatic cyc(input logic [1:0] kl, input logic [1:0] kr,
                     input logic ml, input logic mr, input logic ft);
    key_left = kl; key_right = kr; miss_left = ml; miss_right = mr; frame_tick = ft;
    @(posedge clk); #3;
    key_left = 2'b00; key_right = 2'b00; miss_left = 1'b0; miss_right = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_state", int'(state), 0);
    check("rst_gra_still", int'(gra_still), 1);
    check("rst_countdown", int'(countdown), 0);
    reset = 1'b0;
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("idle_hold", int'(state), 0);

    // Start
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("start_state", int'(state), 1);
    check("start_countdown", int'(countdown), 3);
    ticks(4);
    check("cd_after4_countdown", int'(countdown), 1);
    ticks(2);
    check("cd_done_countdown", int'(countdown), 0);
    check("cd_done_state", int'(state), 2);

    // Serve gating
    cyc(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    check("nonserver_launch", int'(launch), 0);
    check("nonserver_state", int'(state), 2);
    cyc(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    check("serve_launch", int'(launch), 1);
    check("serve_dir", int'(launch_dir), 1);
    check("serve_state", int'(state), 3);
    check("serve_gra_still", int'(gra_still), 0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("launch_count", n_launch, 1);
    check("launch_drop", int'(launch), 0);

    // Simultaneous miss
    cyc(2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    check("sim_score_right", int'(score_right), 1);
    check("sim_score_left", int'(score_left), 0);
    check("sim_serve", int'(serve_side), 0);
    check("sim_state", int'(state), 1);
    check("sim_countdown", int'(countdown), 3);

    // Game end
    ticks(6);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("play2_state", int'(state), 3);
    cyc(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("end_score_right", int'(score_right), 2);
    check("end_state", int'(state), 5);
    check("end_game_over", int'(game_over), 1);
    check("end_winner", int'(winner), 1);
    ticks(3);
    check("over_hold_state", int'(state), 5);
    ticks(1);
    check("over_exit_state", int'(state), 0);
    check("over_exit_score_left", int'(score_left), 0);
    check("over_exit_score_right", int'(score_right), 2);
    cyc(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    check("restart_state", int'(state), 1);
    check("restart_score_right", int'(score_right), 0);
    check("restart_winner", int'(winner), 0);

    // Pause
    ticks(6);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    check("play3_state", int'(state), 3);
    pause_key = 1'b1;
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("pause_state", int'(state), 4);
    check("pause_gra_still", int'(gra_still), 1);
    repeat (4) cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("pause_miss_score_left", int'(score_left), 0);
    check("pause_miss_state", int'(state), 4);
    repeat (4) cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    pause_key = 1'b0;
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("pause_release_state", int'(state), 4);
    pause_key = 1'b1;
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("unpause_state", int'(state), 3);
    check("unpause_gra_still", int'(gra_still), 0);
    pause_key = 1'b0;
    cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset mid-countdown
    cyc(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    check("pt_score_left", int'(score_left), 1);
    check("pt_serve", int'(serve_side), 1);
    ticks(2);
    check("pre_rst_countdown", int'(countdown), 2);
    launch_snap = n_launch;
    reset = 1'b1;
    #1;
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_score_left", int'(score_left), 0);
    check("mid_rst_countdown", int'(countdown), 0);
    check("mid_rst_serve", int'(serve_side), 0);
    check("mid_rst_winner", int'(winner), 0);
    check("mid_rst_launch", int'(launch), 0);
    check("mid_rst_game_over", int'(game_over), 0);
    check("mid_rst_gra_still", int'(gra_still), 1);
    #2;
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    check("rst_key_ignored", int'(state), 0);
    reset = 1'b0;
    repeat (2) cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("post_rst_state", int'(state), 0);
    check("post_rst_no_launch", n_launch, launch_snap);
    cyc(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    check("post_rst_start_state", int'(state), 1);
    check("post_rst_start_countdown", int'(countdown), 3);
    repeat (2) cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
